// File: rtl/biquad_multicanal_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | biquad_multicanal_pkg : coefficient indices, FSM states, requant helpers   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package biquad_multicanal_pkg;

  localparam int NCOEF = 5;

  localparam logic [2:0] C_B0 = 3'd0;
  localparam logic [2:0] C_B1 = 3'd1;
  localparam logic [2:0] C_B2 = 3'd2;
  localparam logic [2:0] C_A1 = 3'd3;
  localparam logic [2:0] C_A2 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A1   = 3'd1,
    S_A2   = 3'd2,
    S_F    = 3'd3,
    S_B0   = 3'd4,
    S_B1   = 3'd5,
    S_B2   = 3'd6,
    S_OUT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    MAC_HOLD = 3'd0,
    MAC_USUB = 3'd1,
    MAC_SUB  = 3'd2,
    MAC_LOAD = 3'd3,
    MAC_ADD  = 3'd4
  } mac_op_t;

  function automatic int acc_w(input int w);
    return 2 * w + 3;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clip a wide signed value into the range of a w-bit two's complement word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/biquad_multicanal_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | biquad_multicanal_if : sample, result and coefficient bus of the biquad   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface biquad_multicanal_if
  import biquad_multicanal_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 2,
  parameter int NSETS = 4
);
  localparam int CHW  = idx_w(NCH);
  localparam int SETW = idx_w(NSETS);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] uk;
  logic [CHW-1:0]          in_ch;
  logic [SETW-1:0]         in_set;
  logic                    out_valid;
  logic signed [WIDTH-1:0] yk;
  logic [CHW-1:0]          out_ch;
  logic                    coef_we;
  logic [SETW-1:0]         coef_set;
  logic [2:0]              coef_idx;
  logic signed [WIDTH-1:0] coef_data;
  logic                    clr_hist;
  logic                    ovf;
  logic                    clr_ovf;

  modport master (
    output in_valid, uk, in_ch, in_set, coef_we, coef_set, coef_idx, coef_data,
           clr_hist, clr_ovf,
    input  in_ready, out_valid, yk, out_ch, ovf
  );

  modport slave (
    input  in_valid, uk, in_ch, in_set, coef_we, coef_set, coef_idx, coef_data,
           clr_hist, clr_ovf,
    output in_ready, out_valid, yk, out_ch, ovf
  );
endinterface
`default_nettype wire

// File: rtl/biquad_multicanal_mac.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | biquad_mac : shared signed multiply-accumulate with requantise/saturate   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module biquad_mac
  import biquad_multicanal_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  mac_op_t                 op,
  input  logic signed [WIDTH-1:0] u,
  input  logic signed [WIDTH-1:0] coef,
  input  logic signed [WIDTH-1:0] smp,
  output logic signed [WIDTH-1:0] q,
  output logic                    clip
);
  localparam int ACCW = acc_w(WIDTH);

  logic signed [ACCW-1:0]    acc_q;
  logic signed [ACCW-1:0]    acc_d;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACCW-1:0]    prod_ext;
  logic signed [ACCW-1:0]    u_ext;
  logic signed [ACCW-1:0]    shifted;
  logic signed [63:0]        wide;
  logic signed [63:0]        sat;

  always_comb begin
    prod     = coef * smp;
    prod_ext = ACCW'(prod);
    u_ext    = ACCW'(u) <<< FRAC;

    acc_d = acc_q;
    case (op)
      MAC_USUB: acc_d = u_ext - prod_ext;
      MAC_SUB:  acc_d = acc_q - prod_ext;
      MAC_LOAD: acc_d = prod_ext;
      MAC_ADD:  acc_d = acc_q + prod_ext;
      default:  acc_d = acc_q;
    endcase

    // Arithmetic shift gives floor rounding before the clip.
    shifted = acc_q >>> FRAC;
    wide    = 64'(shifted);
    sat     = saturate(wide, WIDTH);
    q       = WIDTH'(sat);
    clip    = (sat != wide);
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
endmodule
`default_nettype wire

// File: rtl/biquad_multicanal.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | biquad_multicanal : multichannel DF-II biquad, one shared MAC, 8-cycle seq |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module biquad_multicanal
  import biquad_multicanal_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int NCH   = 2,
  parameter int NSETS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  biquad_multicanal_if.slave      bus
);
  localparam int CHW  = idx_w(NCH);
  localparam int SETW = idx_w(NSETS);

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] u_q, u_d;
  logic [CHW-1:0]          ch_q, ch_d;
  logic [SETW-1:0]         set_q, set_d;
  logic signed [WIDTH-1:0] fk_q, fk_d;
  logic signed [WIDTH-1:0] yk_q, yk_d;
  logic [CHW-1:0]          out_ch_q, out_ch_d;
  logic                    ovf_q, ovf_d;
  logic signed [WIDTH-1:0] coef_q [NSETS][NCOEF];
  logic signed [WIDTH-1:0] coef_d [NSETS][NCOEF];
  logic signed [WIDTH-1:0] f1_q [NCH];
  logic signed [WIDTH-1:0] f1_d [NCH];
  logic signed [WIDTH-1:0] f2_q [NCH];
  logic signed [WIDTH-1:0] f2_d [NCH];

  mac_op_t                 mac_op;
  logic signed [WIDTH-1:0] mac_coef;
  logic signed [WIDTH-1:0] mac_smp;
  logic signed [WIDTH-1:0] mac_q;
  logic                    mac_clip;
  logic                    in_idle;
  logic                    in_out;

  biquad_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .op    (mac_op),
    .u     (u_q),
    .coef  (mac_coef),
    .smp   (mac_smp),
    .q     (mac_q),
    .clip  (mac_clip)
  );

  assign in_idle = (state_q == S_IDLE);
  assign in_out  = (state_q == S_OUT);

  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    ch_d     = ch_q;
    set_d    = set_q;
    fk_d     = fk_q;
    yk_d     = yk_q;
    out_ch_d = out_ch_q;
    coef_d   = coef_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    ovf_d    = ovf_q & ~bus.clr_ovf;
    mac_op   = MAC_HOLD;
    mac_coef = '0;
    mac_smp  = '0;

    case (state_q)
      S_IDLE: begin
        // Coefficient write and history clear land on the accept edge, so the
        // sample accepted in the same cycle already sees them.
        if (bus.coef_we && (bus.coef_idx < 3'(NCOEF)) && (int'(bus.coef_set) < NSETS))
          coef_d[bus.coef_set][bus.coef_idx] = bus.coef_data;
        if (bus.clr_hist) begin
          for (int c = 0; c < NCH; c++) begin
            f1_d[c] = '0;
            f2_d[c] = '0;
          end
        end
        if (bus.in_valid) begin
          u_d     = bus.uk;
          ch_d    = bus.in_ch;
          set_d   = bus.in_set;
          state_d = S_A1;
        end
      end
      S_A1: begin
        mac_op   = MAC_USUB;
        mac_coef = coef_q[set_q][C_A1];
        mac_smp  = f1_q[ch_q];
        state_d  = S_A2;
      end
      S_A2: begin
        mac_op   = MAC_SUB;
        mac_coef = coef_q[set_q][C_A2];
        mac_smp  = f2_q[ch_q];
        state_d  = S_F;
      end
      S_F: begin
        fk_d    = mac_q;
        if (mac_clip) ovf_d = 1'b1;
        state_d = S_B0;
      end
      S_B0: begin
        mac_op   = MAC_LOAD;
        mac_coef = coef_q[set_q][C_B0];
        mac_smp  = fk_q;
        state_d  = S_B1;
      end
      S_B1: begin
        mac_op   = MAC_ADD;
        mac_coef = coef_q[set_q][C_B1];
        mac_smp  = f1_q[ch_q];
        state_d  = S_B2;
      end
      S_B2: begin
        mac_op   = MAC_ADD;
        mac_coef = coef_q[set_q][C_B2];
        mac_smp  = f2_q[ch_q];
        state_d  = S_OUT;
      end
      S_OUT: begin
        yk_d        = mac_q;
        out_ch_d    = ch_q;
        f2_d[ch_q]  = f1_q[ch_q];
        f1_d[ch_q]  = fk_q;
        if (mac_clip) ovf_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      u_q      <= '0;
      ch_q     <= '0;
      set_q    <= '0;
      fk_q     <= '0;
      yk_q     <= '0;
      out_ch_q <= '0;
      ovf_q    <= 1'b0;
      coef_q   <= '{default: '0};
      f1_q     <= '{default: '0};
      f2_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      ch_q     <= ch_d;
      set_q    <= set_d;
      fk_q     <= fk_d;
      yk_q     <= yk_d;
      out_ch_q <= out_ch_d;
      ovf_q    <= ovf_d;
      coef_q   <= coef_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
    end
  end

  // The result is presented straight from the MAC during S_OUT and held after.
  assign bus.in_ready  = in_idle;
  assign bus.out_valid = in_out;
  assign bus.yk        = in_out ? mac_q : yk_q;
  assign bus.out_ch    = in_out ? ch_q : out_ch_q;
  assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_biquad_multicanal.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_biquad_multicanal : directed + random bench with arithmetic ref model  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_biquad_multicanal;
  localparam int     WIDTH = 16;
  localparam int     FRAC  = 8;
  localparam int     NCH   = 2;
  localparam int     NSETS = 4;
  localparam int     CHW   = 1;
  localparam int     SETW  = 2;
  localparam longint YMAX  = 32767;
  localparam longint YMIN  = -32768;
  localparam longint ONE   = 256;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  biquad_multicanal_if #(.WIDTH(WIDTH), .NCH(NCH), .NSETS(NSETS)) bus ();

  biquad_multicanal #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .NCH   (NCH),
    .NSETS (NSETS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: coefficient table, per-channel history, sticky overflow.
  longint m_coef [NSETS][5];
  longint m_f1 [NCH];
  longint m_f2 [NCH];
  bit     m_ovf;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++)
      for (int i = 0; i < 5; i++) m_coef[s][i] = 0;
    for (int c = 0; c < NCH; c++) begin
      m_f1[c] = 0;
      m_f2[c] = 0;
    end
    m_ovf = 0;
  endtask

  function automatic longint requant(input longint acc);
    longint v;
    v = acc >>> FRAC;
    if (v > YMAX) begin m_ovf = 1; return YMAX; end
    if (v < YMIN) begin m_ovf = 1; return YMIN; end
    return v;
  endfunction

  task automatic model_step(input longint u, input int ch, input int set, output longint y);
    longint f;
    f = requant(u * ONE - m_coef[set][3] * m_f1[ch] - m_coef[set][4] * m_f2[ch]);
    y = requant(m_coef[set][0] * f + m_coef[set][1] * m_f1[ch] + m_coef[set][2] * m_f2[ch]);
    m_f2[ch] = m_f1[ch];
    m_f1[ch] = f;
  endtask

  task automatic write_coef(input int set, input int idx, input longint val);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_set  = SETW'(set);
    bus.coef_idx  = 3'(idx);
    bus.coef_data = WIDTH'(val);
    @(negedge clk);
    bus.coef_we = 1'b0;
    if (idx < 5) m_coef[set][idx] = val;
  endtask

  task automatic clear_hist();
    @(negedge clk);
    bus.clr_hist = 1'b1;
    @(negedge clk);
    bus.clr_hist = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_f1[c] = 0;
      m_f2[c] = 0;
    end
  endtask

  task automatic check_ovf(input string tag);
    @(negedge clk);
    chk(tag, longint'(bus.ovf), longint'(m_ovf));
  endtask

  // One sample through the filter; optionally fires a coefficient write while busy.
  task automatic run_sample(input string tag, input longint u, input int ch, input int set,
                            input int bw_cyc, input int bw_idx, input longint bw_val,
                            output longint y_dut);
    longint y_exp;
    int     lat;
    lat   = -1;
    y_dut = 0;
    @(negedge clk);
    chk({tag, "_ready"}, longint'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.uk       = WIDTH'(u);
    bus.in_ch    = CHW'(ch);
    bus.in_set   = SETW'(set);
    model_step(u, ch, set, y_exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == bw_cyc) begin
        bus.coef_we   = 1'b1;
        bus.coef_set  = SETW'(set);
        bus.coef_idx  = 3'(bw_idx);
        bus.coef_data = WIDTH'(bw_val);
      end else begin
        bus.coef_we = 1'b0;
      end
      if (bus.out_valid === 1'b1) begin
        lat   = cyc;
        y_dut = longint'(bus.yk);
        chk({tag, "_out_ch"}, longint'(bus.out_ch), longint'(ch));
        break;
      end
    end
    chk({tag, "_latency"}, longint'(lat), 7);
    chk({tag, "_yk"}, y_dut, y_exp);
  endtask

  initial begin
    longint y;
    longint e1, e2, y1;
    int     lows, lat2, seen;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.uk        = '0;
    bus.in_ch     = '0;
    bus.in_set    = '0;
    bus.coef_we   = 1'b0;
    bus.coef_set  = '0;
    bus.coef_idx  = '0;
    bus.coef_data = '0;
    bus.clr_hist  = 1'b0;
    bus.clr_ovf   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_yk", longint'(bus.yk), 0);
    chk("rst_out_ch", longint'(bus.out_ch), 0);
    chk("rst_ovf", longint'(bus.ovf), 0);

    // Passthrough
    write_coef(0, 0, 256);
    run_sample("pass", 100, 0, 0, 0, 0, 0, y);
    chk("pass_const", y, 100);
    check_ovf("pass_ovf");

    // First-order recursion, a1 = -0.5
    write_coef(0, 3, -128);
    clear_hist();
    for (int k = 0; k < 5; k++) begin
      run_sample($sformatf("rec%0d", k), (k == 0) ? 256 : 0, 0, 0, 0, 0, 0, y);
      chk($sformatf("rec%0d_const", k), y, longint'(256 >> k));
    end

    // Saturation and floor rounding
    write_coef(2, 0, 1024);
    run_sample("sat_pos", 20000, 0, 2, 0, 0, 0, y);
    chk("sat_pos_const", y, YMAX);
    check_ovf("sat_pos_ovf");
    chk("sat_pos_ovf_set", longint'(bus.ovf), 1);
    run_sample("sat_neg", -20000, 0, 2, 0, 0, 0, y);
    chk("sat_neg_const", y, YMIN);
    write_coef(3, 0, 128);
    run_sample("floor", -3, 0, 3, 0, 0, 0, y);
    chk("floor_const", y, -2);
    @(negedge clk);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    m_ovf = 0;
    chk("clr_ovf", longint'(bus.ovf), 0);

    // Independent channels and sets, interleaved
    write_coef(1, 0, 256);
    write_coef(1, 3, -128);
    clear_hist();
    for (int k = 0; k < 4; k++) begin
      run_sample($sformatf("ch0_%0d", k), (k == 0) ? 256 : 0, 0, 1, 0, 0, 0, y);
      chk($sformatf("ch0_%0d_const", k), y, longint'(256 >> k));
      run_sample($sformatf("ch1_%0d", k), 0, 1, 0, 0, 0, 0, y);
      chk($sformatf("ch1_%0d_const", k), y, 0);
    end

    // Coefficient write while busy is dropped; the same write in IDLE lands
    write_coef(3, 0, 256);
    run_sample("busy_wr", 100, 0, 3, 2, 0, 512, y);
    chk("busy_wr_const", y, 100);
    write_coef(3, 0, 512);
    run_sample("idle_wr", 100, 0, 3, 0, 0, 0, y);
    chk("idle_wr_const", y, 200);

    // in_valid held high: second sample waits exactly 7 busy cycles
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.uk       = 16'sd50;
    bus.in_ch    = '0;
    bus.in_set   = 2'd3;
    model_step(50, 0, 3, e1);
    model_step(70, 0, 3, e2);
    lows = 0;
    y1   = -1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.uk = 16'sd70;
      if (bus.in_ready !== 1'b1) lows++;
      if (cyc == 7 && bus.out_valid === 1'b1) y1 = longint'(bus.yk);
    end
    chk("b2b_ready_low", longint'(lows), 7);
    chk("b2b_first_yk", y1, e1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat2 = -1;
    y    = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat2 = cyc;
        y    = longint'(bus.yk);
        break;
      end
    end
    chk("b2b_second_lat", longint'(lat2), 7);
    chk("b2b_second_yk", y, e2);

    // Randomised traffic with coefficient updates and history clears
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0)
        write_coef(int'($urandom_range(0, NSETS - 1)), int'($urandom_range(0, 7)),
                   longint'($urandom_range(0, 400)) - 200);
      if ($urandom_range(0, 7) == 0) clear_hist();
      run_sample($sformatf("rnd%0d", n), longint'($urandom_range(0, 60000)) - 30000,
                 int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, NSETS - 1)),
                 0, 0, 0, y);
      check_ovf($sformatf("rnd%0d_ovf", n));
    end

    // Reset in S_B1 drops the sample and clears everything
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.uk       = 16'sd1000;
    bus.in_ch    = '0;
    bus.in_set   = '0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    seen = 0;
    @(negedge clk);
    chk("rst_mid_in_ready", longint'(bus.in_ready), 1);
    chk("rst_mid_yk", longint'(bus.yk), 0);
    chk("rst_mid_ovf", longint'(bus.ovf), 0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    chk("rst_mid_no_valid", longint'(seen), 0);
    write_coef(0, 0, 256);
    write_coef(0, 3, -128);
    run_sample("post_rst", 0, 0, 0, 0, 0, 0, y);
    chk("post_rst_const", y, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/biquad_multicanal.md
# biquad_multicanal

Parametrised second-order IIR section (direct form II) with an internal sequencer, a single time-shared multiplier, NSETS run-time-loadable coefficient sets and NCH independent channels. It replaces the fixed per-filter datapaths (one hard-wired section per cutoff, driven by externally generated register enables) with one block that owns its own control FSM. It sits between the ADC sample path and the DAC output stage.

## Interface
Parameters:
- WIDTH, 16, signed sample/coefficient width (two's complement)
- FRAC, 8, fractional bits of samples and coefficients (1.0 = 2^FRAC)
- NCH, 2, number of independent channels (history state per channel)
- NSETS, 4, number of coefficient sets

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears FSM, history, coefficients, outputs
- in_valid  in  1  sample offered
- in_ready  out  1  high only in IDLE
- uk  in  WIDTH  input sample u(k)
- in_ch  in  max(1,$clog2(NCH))  channel of uk
- in_set  in  max(1,$clog2(NSETS))  coefficient set for this sample
- out_valid  out  1  one-cycle pulse, yk/out_ch valid
- yk  out  WIDTH  output y(k), held until next out_valid
- out_ch  out  max(1,$clog2(NCH))  channel of yk
- coef_we  in  1  coefficient write strobe
- coef_set  in  max(1,$clog2(NSETS))  set written
- coef_idx  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 ignored
- coef_data  in  WIDTH  coefficient value
- clr_hist  in  1  zero all channel histories (honoured in IDLE only)
- ovf  out  1  sticky saturation flag
- clr_ovf  in  1  clears ovf (set wins if same cycle)

## Operation
- f(k) = u(k) − a1·f(k−1) − a2·f(k−2); y(k) = b0·f(k) + b1·f(k−1) + b2·f(k−2).
- Accumulator signed 2·WIDTH+3 bits; u enters as uk<<FRAC.
- Requantisation: arithmetic shift right by FRAC (floor), then saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; any clip of f or y sets ovf.
- FSM: IDLE → S_A1 (acc=u<<FRAC − a1·f1) → S_A2 (acc −= a2·f2) → S_F (fk=sat(acc)) → S_B0 (acc=b0·fk) → S_B1 (acc += b1·f1) → S_B2 (acc += b2·f2) → S_OUT → IDLE.
- IDLE→S_A1 on in_valid && in_ready; uk, in_ch, in_set latched at that edge.
- S_OUT: yk=sat(acc), out_ch=latched channel, out_valid=1; history of that channel only: f2←f1, f1←fk.
- Coefficient writes applied in IDLE only; ignored (silently) in any other state. Write and accept in same IDLE cycle: write lands; the accepted sample uses the new value.
- clr_hist in IDLE zeroes all f1/f2; outside IDLE ignored. clr_hist with accept in same cycle: clear first, sample sees zero history.
- Reset values: in_ready=1 (first cycle after reset released), out_valid=0, yk=0, out_ch=0, ovf=0, all coefficients 0, all histories 0.
- Reset mid-operation: sample discarded, no out_valid, history unchanged by that sample (all zero).

## Timing
- Accept edge E0; out_valid high during the 7th cycle after E0 (cycle S_OUT); in_ready high again the following cycle.
- Throughput: one sample per 8 cycles; back-to-back in_valid gets in_ready=0 for 7 cycles.
- One multiply per cycle; multiplier output not pipelined (combinational into accumulator).

## Structure
- Shared package: coefficient index constants (B0..A2), FSM state enum, accumulator width function, saturate function.
- One sub-module: biquad_mac (WIDTH×WIDTH signed multiply, add/sub/load into accumulator, requantise+saturate with overflow flag). FSM, coefficient array and per-channel history stay in the top.

## Test plan
- Passthrough: set0 b0=256, rest 0; uk=100 ch0 → yk=100, out_valid exactly 7 cycles after accept, ovf=0.
- Recursion: a1=−128, b0=256; impulse uk=256 then zeros on ch0 → yk=256,128,64,32,16.
- Saturation/rounding: b0=1024, uk=20000 → yk=32767, ovf=1; uk=−20000 → −32768; b0=128, uk=−3 → yk=−2; clr_ovf → ovf=0.
- Channels/sets: ch0 impulse with set1 (a1=−128), ch1 zeros with set0 interleaved → ch1 yk=0 always, ch0 sequence identical to solo run.
- Handshake/reset: in_valid held high → in_ready low 7 cycles, second sample accepted on 8th; reset asserted in S_B1 → no out_valid, in_ready=1 cycle after release, yk=0.
- Busy writes: coef_we b0=512 during S_A2 → ignored, yk uses old b0; same write in IDLE → next output doubled.
